// File: rtl/seg7_scan_driver.sv
// Multiplexed 8-digit hex scan driver for active-low common-anode 7-segment displays.
// Optional macro SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always lit).
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] numero_entrada,
  input  logic        power_on,
  output logic [7:0]  ANODO,
  output logic [6:0]  SEG,
  output logic        frame_done
);

  localparam int               CNT_W    = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] count_reg;
  logic [2:0]       index_reg;
  logic [31:0]      snapshot_reg;
  logic [7:0]       anodo_reg;
  logic [6:0]       seg_reg;
  logic             frame_done_reg;

  logic             tick;
  logic             frame_end;
  logic [7:0]       digit_lit;
  logic [3:0]       nibble;
  logic [7:0]       anodo_next;
  logic [6:0]       seg_next;

  assign tick      = (count_reg == CNT_LAST);
  assign frame_end = tick && (index_reg == 3'd7);
  assign nibble    = snapshot_reg[{index_reg, 2'b00} +: 4];

  function automatic logic [6:0] hex_decode(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0: pattern = 7'h40;
      4'h1: pattern = 7'h79;
      4'h2: pattern = 7'h24;
      4'h3: pattern = 7'h30;
      4'h4: pattern = 7'h19;
      4'h5: pattern = 7'h12;
      4'h6: pattern = 7'h02;
      4'h7: pattern = 7'h78;
      4'h8: pattern = 7'h00;
      4'h9: pattern = 7'h10;
      4'hA: pattern = 7'h08;
      4'hB: pattern = 7'h03;
      4'hC: pattern = 7'h46;
      4'hD: pattern = 7'h21;
      4'hE: pattern = 7'h06;
      default: pattern = 7'h0E;
    endcase
    return pattern;
  endfunction

  // A digit is lit unless it is a leading zero (only when blanking is compiled in).
  for (genvar gi = 0; gi < 8; gi++) begin : g_lit
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (gi == 0) begin : g_first
      assign digit_lit[gi] = 1'b1;
    end else begin : g_upper
      assign digit_lit[gi] = |snapshot_reg[31:4*gi];
    end
`else
    assign digit_lit[gi] = 1'b1;
`endif
  end

  always_comb begin
    anodo_next = 8'hFF;
    seg_next   = 7'h7F;
    if (power_on && digit_lit[index_reg]) begin
      anodo_next[index_reg] = 1'b0;
      seg_next              = hex_decode(nibble);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg      <= '0;
      index_reg      <= 3'd0;
      snapshot_reg   <= 32'h0;
      anodo_reg      <= 8'hFF;
      seg_reg        <= 7'h7F;
      frame_done_reg <= 1'b0;
    end else begin
      count_reg <= tick ? '0 : count_reg + 1'b1;
      if (tick) begin
        index_reg <= index_reg + 3'd1;
      end
      // The displayed value only changes at frame boundaries to avoid torn numbers.
      if (frame_end) begin
        snapshot_reg <= numero_entrada;
      end
      frame_done_reg <= frame_end;
      anodo_reg      <= anodo_next;
      seg_reg        <= seg_next;
    end
  end

  assign ANODO      = anodo_reg;
  assign SEG        = seg_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed self-checking bench for seg7_scan_driver with REFRESH_DIV=4 (32-cycle frames).
module tb_seg7_scan_driver;

  logic        clk;
  logic        reset;
  logic [31:0] numero_entrada;
  logic        power_on;
  logic [7:0]  ANODO;
  logic [6:0]  SEG;
  logic        frame_done;

  int compared;
  int mismatched;

  seg7_scan_driver #(.REFRESH_DIV(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .numero_entrada (numero_entrada),
    .power_on       (power_on),
    .ANODO          (ANODO),
    .SEG            (SEG),
    .frame_done     (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advances until frame_done is seen (inclusive), within a cycle budget.
  task automatic wait_frame(output bit found);
    int n;
    n = 0;
    found = 1'b0;
    while (!found && n < 100) begin
      step();
      n++;
      if (frame_done === 1'b1) found = 1'b1;
    end
  endtask

  function automatic logic [7:0] anode_for(input int k);
    logic [7:0] a;
    a = 8'hFF;
    a[k] = 1'b0;
    return a;
  endfunction

  task automatic test_reset();
    logic [7:0] exp_a;
    logic [6:0] exp_s;
    reset = 1'b1;
    power_on = 1'b1;
    numero_entrada = 32'h89ABCDEF;
    step();
    step();
    compared++;
    if (ANODO !== 8'hFF || SEG !== 7'h7F || frame_done !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_values: ANODO=%h SEG=%h fd=%b required FF 7F 0", ANODO, SEG, frame_done);
    end
    reset = 1'b0;
    for (int p = 1; p <= 5; p++) begin
      step();
      if (p <= 4) begin
        exp_a = 8'hFE;
        exp_s = 7'h40;
      end else begin
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        exp_a = 8'hFF;
        exp_s = 7'h7F;
`else
        exp_a = 8'hFD;
        exp_s = 7'h40;
`endif
      end
      compared++;
      if (ANODO !== exp_a || SEG !== exp_s || frame_done !== 1'b0) begin
        mismatched++;
        $display("FAIL first_tick p=%0d: ANODO=%h SEG=%h fd=%b required %h %h 0", p, ANODO, SEG, frame_done, exp_a, exp_s);
      end
    end
    $display("test_reset done");
  endtask

  task automatic test_frame();
    bit found;
    logic [6:0] exp_seg [8];
    exp_seg[0] = 7'h0E; exp_seg[1] = 7'h06; exp_seg[2] = 7'h21; exp_seg[3] = 7'h46;
    exp_seg[4] = 7'h03; exp_seg[5] = 7'h08; exp_seg[6] = 7'h10; exp_seg[7] = 7'h00;
    wait_frame(found);
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL frame_wait: frame_done actual=0 required=1 within budget");
    end
    wait_frame(found);
    for (int p = 1; p <= 32; p++) begin
      int k;
      logic exp_fd;
      step();
      k = (p - 1) / 4;
      exp_fd = (p == 32);
      compared++;
      if (ANODO !== anode_for(k) || SEG !== exp_seg[k] || frame_done !== exp_fd) begin
        mismatched++;
        $display("FAIL frame_scan p=%0d: ANODO=%h SEG=%h fd=%b required %h %h %b", p, ANODO, SEG, frame_done, anode_for(k), exp_seg[k], exp_fd);
      end
    end
    $display("test_frame done");
  endtask

  task automatic test_midframe_change();
    bit found;
    numero_entrada = 32'h11111111;
    wait_frame(found);
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL change_wait: frame_done actual=0 required=1 within budget");
    end
    for (int p = 1; p <= 64; p++) begin
      int k;
      logic [6:0] exp_s;
      step();
      k = ((p - 1) / 4) % 8;
      exp_s = (p <= 32) ? 7'h79 : 7'h24;
      compared++;
      if (ANODO !== anode_for(k) || SEG !== exp_s) begin
        mismatched++;
        $display("FAIL midframe_change p=%0d: ANODO=%h SEG=%h required %h %h", p, ANODO, SEG, anode_for(k), exp_s);
      end
      if (p == 13) numero_entrada = 32'h22222222;
    end
    $display("test_midframe_change done");
  endtask

  task automatic test_power();
    // Entered right on a frame_done edge; position p counts cycles after it.
    for (int p = 1; p <= 32; p++) begin
      int k;
      logic [7:0] exp_a;
      logic [6:0] exp_s;
      step();
      k = (p - 1) / 4;
      if (p >= 2 && p <= 11) begin
        exp_a = 8'hFF;
        exp_s = 7'h7F;
      end else begin
        exp_a = anode_for(k);
        exp_s = 7'h24;
      end
      compared++;
      if (ANODO !== exp_a || SEG !== exp_s || frame_done !== (p == 32)) begin
        mismatched++;
        $display("FAIL power p=%0d: ANODO=%h SEG=%h fd=%b required %h %h %b", p, ANODO, SEG, frame_done, exp_a, exp_s, (p == 32));
      end
      if (p == 1) power_on = 1'b0;
      if (p == 11) power_on = 1'b1;
    end
    $display("test_power done");
  endtask

  task automatic test_lzb();
    bit found;
    numero_entrada = 32'h000000A5;
    wait_frame(found);
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL lzb_wait: frame_done actual=0 required=1 within budget");
    end
    numero_entrada = 32'h0;
    for (int p = 1; p <= 64; p++) begin
      int k;
      logic [7:0] exp_a;
      logic [6:0] exp_s;
      step();
      k = ((p - 1) / 4) % 8;
      if (p <= 32) begin
        exp_s = (k == 0) ? 7'h12 : (k == 1) ? 7'h08 : 7'h40;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (k >= 2) exp_s = 7'h7F;
        exp_a = (k >= 2) ? 8'hFF : anode_for(k);
`else
        exp_a = anode_for(k);
`endif
      end else begin
        exp_s = 7'h40;
        exp_a = anode_for(k);
`ifdef SEG7_LEADING_ZERO_BLANK_EN
        if (k >= 1) begin
          exp_s = 7'h7F;
          exp_a = 8'hFF;
        end
`endif
      end
      compared++;
      if (ANODO !== exp_a || SEG !== exp_s) begin
        mismatched++;
        $display("FAIL lzb p=%0d: ANODO=%h SEG=%h required %h %h", p, ANODO, SEG, exp_a, exp_s);
      end
    end
    $display("test_lzb done");
  endtask

  task automatic test_reset_midframe();
    bit found;
    numero_entrada = 32'h12345678;
    wait_frame(found);
    compared++;
    if (!found) begin
      mismatched++;
      $display("FAIL rst_wait: frame_done actual=0 required=1 within budget");
    end
    repeat (21) step();
    compared++;
    if (ANODO !== 8'hDF || SEG !== 7'h30) begin
      mismatched++;
      $display("FAIL rst_digit5: ANODO=%h SEG=%h required DF 30", ANODO, SEG);
    end
    reset = 1'b1;
    step();
    compared++;
    if (ANODO !== 8'hFF || SEG !== 7'h7F || frame_done !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_mid: ANODO=%h SEG=%h fd=%b required FF 7F 0", ANODO, SEG, frame_done);
    end
    reset = 1'b0;
    step();
    compared++;
    if (ANODO !== 8'hFE || SEG !== 7'h40) begin
      mismatched++;
      $display("FAIL rst_snapshot_d0: ANODO=%h SEG=%h required FE 40", ANODO, SEG);
    end
    repeat (4) step();
    compared++;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (ANODO !== 8'hFF || SEG !== 7'h7F) begin
      mismatched++;
      $display("FAIL rst_snapshot_d1: ANODO=%h SEG=%h required FF 7F", ANODO, SEG);
    end
`else
    if (ANODO !== 8'hFD || SEG !== 7'h40) begin
      mismatched++;
      $display("FAIL rst_snapshot_d1: ANODO=%h SEG=%h required FD 40", ANODO, SEG);
    end
`endif
    $display("test_reset_midframe done");
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    reset = 1'b1;
    power_on = 1'b1;
    numero_entrada = 32'h0;
    test_reset();
    test_frame();
    test_midframe_change();
    test_power();
    test_lzb();
    test_reset_midframe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 The block SHALL have parameter REFRESH_DIV, default 100000, giving the clk cycles per digit slot; legal values are 2 or more.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, 100 MHz on board.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port numero_entrada, input, 32 bits: eight hex nibbles to display, nibble k on digit k.
REQ-005 The block SHALL have port power_on, input, 1 bit: 0 blanks the display.
REQ-006 The block SHALL have port ANODO, output, 8 bits: digit enables, active-low.
REQ-007 The block SHALL have port SEG, output, 7 bits: segments, active-low, SEG[0]=a through SEG[6]=g.
REQ-008 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse when a full 8-digit scan completes.

Function
REQ-009 The prescaler SHALL count 0..REFRESH_DIV-1, wrap to 0, and assert an internal tick on the cycle it equals REFRESH_DIV-1.
REQ-010 The 3-bit digit index SHALL advance by 1 on each tick and wrap from 7 to 0.
REQ-011 On a tick with index==7, the snapshot register SHALL load numero_entrada and frame_done SHALL pulse high for exactly one cycle; changes to numero_entrada mid-frame SHALL NOT appear until the next frame.
REQ-012 ANODO and SEG SHALL be registered, reflecting the index and snapshot values of the previous cycle (1-cycle latency), and SHALL be glitch-free.
REQ-013 For index k the block SHALL drive ANODO to all ones except bit k low, and SEG to the hex decode of snapshot[4k+3:4k].
REQ-014 The hex decode SHALL be 0:40 1:79 2:24 3:30 4:19 5:12 6:02 7:78 8:00 9:10 A:08 b:03 C:46 d:21 E:06 F:0E, with all values in hex.
REQ-015 When power_on=0, the block SHALL drive ANODO=8'hFF and SEG=7'h7F from the next cycle, while the prescaler, index, snapshot and frame_done continue to run.
REQ-016 A blanked digit SHALL drive ANODO bit k high, and SEG=7'h7F.

Reset
REQ-017 While reset=1 at a clk edge, the block SHALL set prescaler=0, index=0, snapshot=32'h0, ANODO=8'hFF, SEG=7'h7F and frame_done=0.
REQ-018 Reset SHALL take priority over tick, snapshot load and power_on, including when asserted mid-frame.
REQ-019 The first tick after reset release SHALL occur REFRESH_DIV cycles after release.

Configuration
REQ-020 With macro SEG7_LEADING_ZERO_BLANK_EN defined, digit k>0 SHALL be blanked whenever snapshot nibbles k..7 are all zero.
REQ-021 Under SEG7_LEADING_ZERO_BLANK_EN, digit 0 SHALL always be shown, so a value of 0 displays a single "0".
REQ-022 With SEG7_LEADING_ZERO_BLANK_EN undefined, all eight digits SHALL always be shown when power_on=1.

Verification (REFRESH_DIV=4)
REQ-023 The bench SHALL drive reset for 2 cycles, release it, and check ANODO=FF, SEG=7F and frame_done=0 during reset, with the first tick exactly 4 cycles after release.
REQ-024 The bench SHALL hold numero_entrada=32'h89ABCDEF and check that after the first frame_done the next frame shows digit0 ANODO=FE/SEG=0E through digit7 ANODO=7F/SEG=00, each for 4 cycles, with frame_done every 32 cycles.
REQ-025 The bench SHALL change numero_entrada from 32'h11111111 to 32'h22222222 while digit 3 is shown and check that the remaining digits of that frame show 79, and the next frame shows 24.
REQ-026 The bench SHALL drop power_on for 10 cycles and check ANODO=FF/SEG=7F one cycle later; on restore, the scan SHALL resume at the index the free-running counter has reached.
REQ-027 With SEG7_LEADING_ZERO_BLANK_EN, the bench SHALL load numero_entrada=32'h000000A5 and check that only digits 0 and 1 are lit (SEG 12, 08); for 32'h0 only digit 0 SHALL be lit, showing SEG 40.
REQ-028 The bench SHALL assert reset mid-frame with index==5 and check all outputs return to reset values on the next edge and the snapshot reads 0 after release.
